// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the multi-channel timer.
//   reg_e      - per-channel register offsets (word index bits [2:0])
//   CTRL_*     - bit positions inside the CTRL register
//   STAT_*     - bit positions inside the STAT register
package timer_pkg;

    typedef enum logic [2:0] {
        REG_PRE  = 3'd0,
        REG_ARE  = 3'd1,
        REG_CTRL = 3'd2,
        REG_CNT  = 3'd3,
        REG_CMP  = 3'd4,
        REG_STAT = 3'd5,
        REG_EVC  = 3'd6,
        REG_RSV  = 3'd7
    } reg_e;

    localparam int unsigned CTRL_ENA = 0;
    localparam int unsigned CTRL_MOD = 1;
    localparam int unsigned CTRL_CLR = 2;
    localparam int unsigned CTRL_IEN = 3;

    localparam int unsigned STAT_OVF = 0;
    localparam int unsigned STAT_MAT = 1;

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one timer channel - register set, prescaler, counter with
// auto-reload, compare match, sticky flags and a registered interrupt.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr         : write strobe already qualified for this channel
//   reg_sel    : register offset within the channel
//   be, wdata  : byte enables and write data
//   rdata      : combinational read data for reg_sel
//   irq        : registered IEN & (OVF | MAT)
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic [2:0]  reg_sel,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [CNT_W-1:0] pre, are, cnt, cmp, psc;
    logic [CNT_W-1:0] pre_n, are_n, cnt_n, cmp_n, psc_n;
    logic             ena, mode, ien, ovf, mat;
    logic             ena_n, mode_n, ien_n, ovf_n, mat_n, irq_n;
    logic [31:0]      evc, evc_n;

    reg_e             rsel;
    logic             wr_pre, wr_are, wr_ctrl, wr_cnt, wr_cmp, wr_stat;
    logic             ctrl_lo, clr, tick, wrap, hw_evt;
    logic             ovf_set, mat_set;
    logic [CNT_W-1:0] cnt_inc;

    // Only bits below CNT_W exist; each bit follows the enable of its byte.
    function automatic logic [CNT_W-1:0] merge_be(input logic [CNT_W-1:0] old,
                                                  input logic [31:0] din,
                                                  input logic [3:0]  ben);
        logic [CNT_W-1:0] r;
        r = old;
        for (int unsigned k = 0; k < CNT_W; k++) begin
            if (ben[k/8]) r[k] = din[k];
        end
        return r;
    endfunction

    assign rsel = reg_e'(reg_sel);

    always_comb begin
        wr_pre  = wr && (rsel == REG_PRE);
        wr_are  = wr && (rsel == REG_ARE);
        wr_ctrl = wr && (rsel == REG_CTRL);
        wr_cnt  = wr && (rsel == REG_CNT);
        wr_cmp  = wr && (rsel == REG_CMP);
        wr_stat = wr && (rsel == REG_STAT);
        ctrl_lo = wr_ctrl && be[0];
        clr     = ctrl_lo && wdata[CTRL_CLR];

        tick    = ena && (psc == pre);
        wrap    = (cnt == are);
        cnt_inc = wrap ? '0 : cnt + CNT_W'(1);
        // A bus write to CNT or a CLR overrides the whole tick outcome.
        hw_evt  = tick && !clr && !wr_cnt;

        pre_n   = pre;
        are_n   = are;
        cmp_n   = cmp;
        cnt_n   = cnt;
        psc_n   = psc;
        evc_n   = evc;
        ena_n   = ena;
        mode_n  = mode;
        ien_n   = ien;
        ovf_set = 1'b0;
        mat_set = 1'b0;

        if (ena) psc_n = tick ? '0 : psc + CNT_W'(1);

        if (hw_evt) begin
            cnt_n = cnt_inc;
            if (wrap) begin
                ovf_set = 1'b1;
                evc_n   = evc + 32'd1;
                if (mode) ena_n = 1'b0;
            end
            mat_set = (cnt_inc == cmp);
        end

        if (wr_pre) pre_n = merge_be(pre, wdata, be);
        if (wr_are) are_n = merge_be(are, wdata, be);
        if (wr_cmp) cmp_n = merge_be(cmp, wdata, be);
        if (wr_cnt) cnt_n = merge_be(cnt, wdata, be);

        // Bus-written ENA applies after the one-shot clear, so the bus wins.
        if (ctrl_lo) begin
            ena_n  = wdata[CTRL_ENA];
            mode_n = wdata[CTRL_MOD];
            ien_n  = wdata[CTRL_IEN];
        end
        if (clr) begin
            cnt_n = '0;
            psc_n = '0;
            evc_n = '0;
        end

        // Clear first, then set, so a hardware set beats a same-cycle W1C.
        ovf_n = (ovf & ~(wr_stat & be[0] & wdata[STAT_OVF])) | ovf_set;
        mat_n = (mat & ~(wr_stat & be[0] & wdata[STAT_MAT])) | mat_set;
        irq_n = ien & (ovf | mat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre  <= '0;
            are  <= '0;
            cmp  <= '0;
            cnt  <= '0;
            psc  <= '0;
            evc  <= '0;
            ena  <= 1'b0;
            mode <= 1'b0;
            ien  <= 1'b0;
            ovf  <= 1'b0;
            mat  <= 1'b0;
            irq  <= 1'b0;
        end else begin
            pre  <= pre_n;
            are  <= are_n;
            cmp  <= cmp_n;
            cnt  <= cnt_n;
            psc  <= psc_n;
            evc  <= evc_n;
            ena  <= ena_n;
            mode <= mode_n;
            ien  <= ien_n;
            ovf  <= ovf_n;
            mat  <= mat_n;
            irq  <= irq_n;
        end
    end

    always_comb begin
        rdata = '0;
        case (rsel)
            REG_PRE:  rdata = 32'(pre);
            REG_ARE:  rdata = 32'(are);
            REG_CTRL: rdata = {28'd0, ien, 1'b0, mode, ena};
            REG_CNT:  rdata = 32'(cnt);
            REG_CMP:  rdata = 32'(cmp);
            REG_STAT: rdata = {30'd0, mat, ovf};
            REG_EVC:  rdata = evc;
            default:  rdata = '0;
        endcase
    end

endmodule

// File: rtl/timer_multi.sv
// timer_multi: N_CH-channel timer with a memory-mapped register bank.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   write_bus    : write strobe for the addressed word
//   be_bus       : byte enables
//   addr_bus     : byte address; channel = addr[31:5], register = addr[4:2]
//   data_i_bus   : write data
//   data_o_bus   : combinational read data (0 for nonexistent channels)
//   irq_o        : per-channel registered interrupt
module timer_multi
    import timer_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            write_bus,
    input  logic [3:0]      be_bus,
    input  logic [31:0]     addr_bus,
    input  logic [31:0]     data_i_bus,
    output logic [31:0]     data_o_bus,
    output logic [N_CH-1:0] irq_o
);

    logic [31:0] ch_idx;
    logic [2:0]  reg_sel;
    logic [31:0] rd [N_CH];
    logic [1:0]  addr_unused;

    assign ch_idx      = {5'd0, addr_bus[31:5]};
    assign reg_sel     = addr_bus[4:2];
    assign addr_unused = addr_bus[1:0];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk_i),
            .rst_n   (rst_i),
            .wr      (write_bus && (ch_idx == 32'(c))),
            .reg_sel (reg_sel),
            .be      (be_bus),
            .wdata   (data_i_bus),
            .rdata   (rd[c]),
            .irq     (irq_o[c])
        );
    end

    always_comb begin
        data_o_bus = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (ch_idx == c) data_o_bus = rd[c];
        end
    end

endmodule

// File: tb/tb_timer_multi.sv
`timescale 1ns/1ps
module tb_timer_multi;
    import timer_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          write_bus = 1'b0;
    logic [3:0]    be_bus = '0;
    logic [31:0]   addr_bus = '0;
    logic [31:0]   data_i_bus = '0;
    logic [31:0]   data_o_bus;
    logic [N-1:0]  irq_o;

    int checks = 0;
    int failures = 0;

    timer_multi #(.N_CH(N), .CNT_W(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .write_bus  (write_bus),
        .be_bus     (be_bus),
        .addr_bus   (addr_bus),
        .data_i_bus (data_i_bus),
        .data_o_bus (data_o_bus),
        .irq_o      (irq_o)
    );

    always #10 clk_i = ~clk_i;

    // Reference model: register contents per channel as plain variables.
    logic [31:0] m_pre [N], m_are [N], m_cnt [N], m_cmp [N], m_psc [N], m_evc [N];
    bit          m_ena [N], m_mod [N], m_ien [N], m_ovf [N], m_mat [N], m_irq [N];

    function automatic logic [31:0] msk(input logic [31:0] v);
        logic [63:0] m;
        m = (64'd1 << W) - 64'd1;
        return v & m[31:0];
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = n[8*k +: 8];
        return msk(r);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int c, r;
        c = int'(a >> 5);
        r = int'((a >> 2) & 7);
        if (c >= N) return 0;
        case (r)
            0: return m_pre[c];
            1: return m_are[c];
            2: return {28'd0, m_ien[c], 1'b0, m_mod[c], m_ena[c]};
            3: return m_cnt[c];
            4: return m_cmp[c];
            5: return {30'd0, m_mat[c], m_ovf[c]};
            6: return m_evc[c];
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_irq();
        logic [31:0] v;
        v = 0;
        for (int c = 0; c < N; c++) v[c] = m_irq[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_pre[c] = 0; m_are[c] = 0; m_cnt[c] = 0; m_cmp[c] = 0;
            m_psc[c] = 0; m_evc[c] = 0; m_ena[c] = 0; m_mod[c] = 0;
            m_ien[c] = 0; m_ovf[c] = 0; m_mat[c] = 0; m_irq[c] = 0;
        end
    endtask

    // One clock edge of the specification's rules, applied to every channel.
    task automatic model_clock(input bit w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] d);
        int ca, r;
        ca = int'(a >> 5);
        r  = int'((a >> 2) & 7);
        for (int c = 0; c < N; c++) begin
            bit bw, tick, clr, cntw, so, sm, ctl;
            logic [31:0] ncnt, nevc, npsc;
            bit nena;
            bw   = w && (ca == c);
            ctl  = bw && r == 2 && b[0];
            clr  = ctl && d[2];
            cntw = bw && r == 3;
            tick = m_ena[c] && (m_psc[c] == m_pre[c]);
            m_irq[c] = m_ien[c] && (m_ovf[c] || m_mat[c]);
            npsc = m_ena[c] ? (tick ? 0 : msk(m_psc[c] + 1)) : m_psc[c];
            ncnt = m_cnt[c]; nevc = m_evc[c]; nena = m_ena[c]; so = 0; sm = 0;
            if (tick && !clr && !cntw) begin
                if (m_cnt[c] == m_are[c]) begin
                    ncnt = 0; so = 1; nevc = m_evc[c] + 1;
                    if (m_mod[c]) nena = 0;
                end else ncnt = msk(m_cnt[c] + 1);
                sm = (ncnt == m_cmp[c]);
            end
            if (bw && r == 0) m_pre[c] = bmerge(m_pre[c], d, b);
            if (bw && r == 1) m_are[c] = bmerge(m_are[c], d, b);
            if (bw && r == 4) m_cmp[c] = bmerge(m_cmp[c], d, b);
            if (cntw) ncnt = bmerge(m_cnt[c], d, b);
            if (ctl) begin
                nena = d[0]; m_mod[c] = d[1]; m_ien[c] = d[3];
            end
            if (clr) begin
                ncnt = 0; npsc = 0; nevc = 0;
            end
            if (bw && r == 5 && b[0]) begin
                if (d[0]) m_ovf[c] = 0;
                if (d[1]) m_mat[c] = 0;
            end
            if (so) m_ovf[c] = 1;
            if (sm) m_mat[c] = 1;
            m_cnt[c] = ncnt; m_evc[c] = nevc; m_psc[c] = npsc; m_ena[c] = nena;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one bus cycle, compare outputs with the model, then advance both.
    task automatic step(input bit w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d);
        write_bus = w; be_bus = b; addr_bus = a; data_i_bus = d;
        #1;
        chk("rdata", data_o_bus, model_read(a));
        chk("irq", 32'(irq_o), model_irq());
        @(posedge clk_i);
        model_clock(w, b, a, d);
        @(negedge clk_i);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 4'hF, a, d);
    endtask

    task automatic idle(input int n, input logic [31:0] a);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, a, 0);
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        write_bus = 1'b0; addr_bus = a;
        #1;
        v = data_o_bus;
    endtask

    initial begin
        logic [31:0] v;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        chk("irq_in_reset", 32'(irq_o), 0);
        rst_i = 1'b1;

        // Every word of every channel plus one past the last channel reads 0.
        for (int a = 0; a < (N + 1) * 32; a += 4) begin
            peek(a, v);
            chk("reset_read", v, 0);
        end
        chk("reset_irq", 32'(irq_o), 0);
        idle(1, 0);

        // Ch0 periodic, PRE=2 ARE=4: ticks every 3 cycles, wrap every 15.
        wr(32'h00, 2); wr(32'h04, 4); wr(32'h08, 1);
        idle(12, 32'h0C);
        peek(32'h0C, v); chk("ch0_cnt4", v, 4);
        peek(32'h14, v); chk("ch0_stat_pre", v, 0);
        idle(3, 32'h0C);
        peek(32'h0C, v); chk("ch0_cnt_wrap", v, 0);
        peek(32'h14, v); chk("ch0_stat_wrap", v, 3);
        peek(32'h18, v); chk("ch0_evc1", v, 1);
        idle(30, 32'h18);
        peek(32'h18, v); chk("ch0_evc3", v, 3);

        // Ch1 one-shot, PRE=0 ARE=3 CMP=2, IEN.
        wr(32'h20, 0); wr(32'h24, 3); wr(32'h30, 2); wr(32'h28, 32'hB);
        idle(2, 32'h34);
        peek(32'h34, v); chk("ch1_mat", v, 2);
        peek(32'h2C, v); chk("ch1_cnt2", v, 2);
        chk("ch1_irq_lag", 32'(irq_o[1]), 0);
        idle(1, 32'h2C);
        chk("ch1_irq_mat", 32'(irq_o[1]), 1);
        idle(1, 32'h2C);
        peek(32'h2C, v); chk("ch1_cnt_wrap", v, 0);
        peek(32'h34, v); chk("ch1_stat_ovf", v, 3);
        peek(32'h28, v); chk("ch1_ena_cleared", v, 32'hA);
        wr(32'h34, 3);
        peek(32'h34, v); chk("ch1_stat_w1c", v, 0);
        chk("ch1_irq_hold", 32'(irq_o[1]), 1);
        idle(1, 32'h34);
        chk("ch1_irq_drop", 32'(irq_o[1]), 0);

        // Byte enables on ch2 ARE.
        wr(32'h44, 32'h11111111);
        step(1'b1, 4'b0101, 32'h44, 32'hAABBCCDD);
        peek(32'h44, v); chk("ch2_be", v, 32'h11BB11DD);

        // Collisions on ch2, PRE=0 ARE=2: wrap on the third edge after ENA.
        wr(32'h40, 0); wr(32'h44, 2); wr(32'h48, 1);
        idle(2, 32'h54);
        step(1'b1, 4'hF, 32'h54, 1);
        peek(32'h54, v); chk("ch2_w1c_vs_set", v & 1, 1);
        wr(32'h4C, 7);
        peek(32'h4C, v); chk("ch2_cnt_write_tick", v, 7);
        wr(32'h48, 5);
        peek(32'h4C, v); chk("ch2_clr_cnt", v, 0);
        peek(32'h58, v); chk("ch2_clr_evc", v, 0);
        peek(32'h48, v); chk("ch2_clr_ctrl", v, 1);

        // Randomized traffic, including the nonexistent channel N.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a, d;
            logic [3:0]  b;
            bit          w;
            a = (32'($urandom_range(0, N)) << 5) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 9));
            b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            w = ($urandom_range(0, 2) == 0);
            step(w, b, a, d);
        end

        // Asynchronous reset mid-count on ch3.
        wr(32'h60, 0); wr(32'h64, 100); wr(32'h68, 5);
        idle(5, 32'h6C);
        peek(32'h6C, v); chk("ch3_cnt5", v, 5);
        #1 rst_i = 1'b0;
        #1 rst_i = 1'b1;
        model_reset();
        peek(32'h6C, v); chk("ch3_async_cnt", v, 0);
        peek(32'h68, v); chk("ch3_async_ctrl", v, 0);
        chk("ch3_async_irq", 32'(irq_o), 0);
        @(negedge clk_i);
        idle(4, 32'h6C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
